// File: rtl/pulse_stretcher_moore_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and counter sizing helper.
package pulse_stretcher_moore_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Width of the gap counter; it only ever holds GAP_LEN-1, and never fewer than one bit.
  function automatic int gap_cnt_width(input int gap_len);
    int w;
    if (gap_len <= 2) begin
      w = 1;
    end else begin
      w = $clog2(gap_len);
    end
    return w;
  endfunction

endpackage

// File: rtl/pulse_stretcher_moore_counter.sv
// Loadable down-counter that saturates at zero and flags when it has reached zero.
module stretch_down_counter
  import pulse_stretcher_moore_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/pulse_stretcher_moore.sv
// Moore pulse stretcher: IDLE -> HIGH (hold_len cycles) -> GAP (GAP_LEN cycles) -> IDLE.
// Define PULSE_STRETCHER_RETRIGGER_EN to let a tick during HIGH reload the hold counter.
module pulse_stretcher_moore
  import pulse_stretcher_moore_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [CNT_W-1:0] hold_len,
  output logic             level,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = gap_cnt_width(GAP_LEN);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : {GAP_W{1'b0}};
  localparam logic GAP_EN = (GAP_LEN > 0) ? 1'b1 : 1'b0;

  state_t state_r;
  state_t next_state_s;
  logic   hold_load_s;
  logic   hold_dec_s;
  logic   hold_zero_s;
  logic   gap_load_s;
  logic   gap_dec_s;
  logic   gap_zero_s;
  logic   done_r;

  // A zero length still yields one high cycle, so the counter holds max(len,1)-1.
  function automatic logic [CNT_W-1:0] hold_load_val(input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] v;
    if (len == {CNT_W{1'b0}}) begin
      v = {CNT_W{1'b0}};
    end else begin
      v = len - CNT_W'(1);
    end
    return v;
  endfunction

  stretch_down_counter #(.W(CNT_W)) u_hold_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load_s),
    .dec      (hold_dec_s),
    .load_val (hold_load_val(hold_len)),
    .zero     (hold_zero_s)
  );

  stretch_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load_s),
    .dec      (gap_dec_s),
    .load_val (GAP_LOAD),
    .zero     (gap_zero_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and counter control.
  always_comb begin
    next_state_s = state_r;
    hold_load_s  = 1'b0;
    hold_dec_s   = 1'b0;
    gap_load_s   = 1'b0;
    gap_dec_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick) begin
          next_state_s = HIGH;
          hold_load_s  = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (tick) begin
          next_state_s = HIGH;
          hold_load_s  = 1'b1;
        end else if (!hold_zero_s) begin
`else
        if (!hold_zero_s) begin
`endif
          next_state_s = HIGH;
          hold_dec_s   = 1'b1;
        end else if (GAP_EN) begin
          next_state_s = GAP;
          gap_load_s   = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GAP: begin
        if (gap_zero_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = GAP;
          gap_dec_s    = 1'b1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // done marks the first low cycle after HIGH; a reset mid-pulse never produces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == HIGH) && (next_state_s != HIGH);
    end
  end

  assign level = (state_r == HIGH);
  assign busy  = (state_r == HIGH) || (state_r == GAP);
  assign done  = done_r;

endmodule

// File: tb/tb_pulse_stretcher_moore.sv
// Directed self-checking bench: default DUT (GAP_LEN=2) and a GAP_LEN=0 DUT share stimulus.
module tb_pulse_stretcher_moore;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] hold_len;
  logic       level, busy, done;
  logic       level0, busy0, done0;

  int checks = 0;
  int errors = 0;

  logic [31:0] lv, bv, dv, lv0, bv0, dv0;
  int hc, dc, hc0, dc0;

  always #5 clk = ~clk;

  pulse_stretcher_moore #(.CNT_W(8), .GAP_LEN(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .hold_len(hold_len),
    .level(level), .busy(busy), .done(done)
  );

  pulse_stretcher_moore #(.CNT_W(8), .GAP_LEN(0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .hold_len(hold_len),
    .level(level0), .busy(busy0), .done(done0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [7:0] len);
    hold_len = len;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Records n cycles of outputs (bit i = cycle i); tick follows tick_mask, hold_len changes at chg_idx.
  task automatic capture(input int n, input logic [31:0] tick_mask, input int chg_idx,
                         input logic [7:0] chg_len);
    lv = 32'h0; bv = 32'h0; dv = 32'h0; lv0 = 32'h0; bv0 = 32'h0; dv0 = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (i == chg_idx) hold_len = chg_len;
      tick = tick_mask[i];
      lv[i] = level;  bv[i] = busy;  dv[i] = done;
      lv0[i] = level0; bv0[i] = busy0; dv0[i] = done0;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && (busy || busy0); i++) step();
    check("idle_timeout", 32'({busy, busy0}), 32'h0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    tick = 1'b0;
    hold_len = 8'd4;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({level, busy, done}), 32'h0);
    check("reset_outs0", 32'({level0, busy0, done0}), 32'h0);
    reset = 1'b0;
    step();

    // Basic 4-cycle pulse
    fire(8'd4);
    capture(10, 32'h0, -1, 8'd0);
    check("len4_level", lv, 32'h0F);
    check("len4_busy", bv, 32'h3F);
    check("len4_done", dv, 32'h10);
    check("len4_level_g0", lv0, 32'h0F);
    check("len4_busy_g0", bv0, 32'h0F);
    check("len4_done_g0", dv0, 32'h10);
    wait_idle();

    // Zero length still gives one high cycle
    fire(8'd0);
    capture(6, 32'h0, -1, 8'd0);
    check("len0_level", lv, 32'h01);
    check("len0_busy", bv, 32'h07);
    check("len0_done", dv, 32'h02);
    check("len0_busy_g0", bv0, 32'h01);
    check("len0_done_g0", dv0, 32'h02);
    wait_idle();

    // All-ones length: 255 high cycles, no wrap
    fire(8'd255);
    hc = 0; dc = 0; hc0 = 0; dc0 = 0;
    for (int i = 0; i < 400; i++) begin
      hc += int'(level); dc += int'(done); hc0 += int'(level0); dc0 += int'(done0);
      step();
    end
    check("len255_high", 32'(hc), 32'd255);
    check("len255_done", 32'(dc), 32'd1);
    check("len255_high_g0", 32'(hc0), 32'd255);
    check("len255_done_g0", 32'(dc0), 32'd1);
    wait_idle();

    // Tick held every cycle
    hold_len = 8'd3;
    tick = 1'b1;
    step();
    capture(12, 32'hFFF, -1, 8'd0);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("cont_level", lv, 32'hFFF);
    check("cont_busy", bv, 32'hFFF);
    check("cont_done", dv, 32'h000);
    check("cont_level_g0", lv0, 32'hFFF);
    check("cont_done_g0", dv0, 32'h000);
`else
    check("cont_level", lv, 32'h1C7);
    check("cont_busy", bv, 32'h7DF);
    check("cont_done", dv, 32'h208);
    check("cont_level_g0", lv0, 32'h777);
    check("cont_done_g0", dv0, 32'h888);
`endif
    wait_idle();

    // Second tick while HIGH
    fire(8'd4);
    capture(10, 32'h4, -1, 8'd0);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("retrig_level", lv, 32'h7F);
    check("retrig_busy", bv, 32'h1FF);
    check("retrig_done", dv, 32'h80);
    check("retrig_level_g0", lv0, 32'h7F);
    check("retrig_done_g0", dv0, 32'h80);
`else
    check("retrig_level", lv, 32'h0F);
    check("retrig_busy", bv, 32'h3F);
    check("retrig_done", dv, 32'h10);
    check("retrig_level_g0", lv0, 32'h0F);
    check("retrig_done_g0", dv0, 32'h10);
`endif
    wait_idle();

    // Tick during GAP (ignored) / in first IDLE cycle for GAP_LEN=0 (accepted)
    fire(8'd4);
    capture(10, 32'h10, -1, 8'd0);
    check("gaptick_level", lv, 32'h0F);
    check("gaptick_busy", bv, 32'h3F);
    check("gaptick_done", dv, 32'h10);
    check("gaptick_level_g0", lv0, 32'h1EF);
    check("gaptick_done_g0", dv0, 32'h210);
    wait_idle();

    // hold_len change mid-pulse has no effect
    fire(8'd4);
    capture(8, 32'h0, 1, 8'd9);
    check("lenchg_level", lv, 32'h0F);
    check("lenchg_level_g0", lv0, 32'h0F);
    hold_len = 8'd4;
    wait_idle();

    // Reset mid-pulse
    fire(8'd4);
    step();
    step();
    reset = 1'b1;
    #1;
    check("rst_mid_outs", 32'({level, busy, done}), 32'h0);
    check("rst_mid_outs0", 32'({level0, busy0, done0}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    capture(6, 32'h0, -1, 8'd0);
    check("rst_mid_nodone", dv, 32'h0);
    check("rst_mid_nolevel", lv, 32'h0);
    check("rst_mid_nodone_g0", dv0, 32'h0);
    fire(8'd4);
    capture(8, 32'h0, -1, 8'd0);
    check("post_rst_level", lv, 32'h0F);
    check("post_rst_busy", bv, 32'h3F);
    check("post_rst_done", dv, 32'h10);
    wait_idle();

    // Reset mid-gap
    fire(8'd4);
    capture(5, 32'h0, -1, 8'd0);
    check("pre_gaprst_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("rst_gap_outs", 32'({level, busy, done}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("rst_gap_idle", 32'({level, busy, done}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher_moore.md
PULSE_STRETCHER_MOORE -- requirements
Module: pulse_stretcher_moore

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of hold_len and the hold counter.
REQ-002 Parameter GAP_LEN, default 2, SHALL set the minimum low cycles after each pulse (0 = no gap).
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 tick  input  1  SHALL be the single-cycle trigger request, synchronous to clk.
REQ-006 hold_len  input  CNT_W  SHALL give the high duration in cycles, sampled only when a tick is accepted.
REQ-007 level  output  1  SHALL be the stretched output level, driven from state only (Moore).
REQ-008 busy  output  1  SHALL be high in HIGH and GAP states.
REQ-009 done  output  1  SHALL be a registered one-cycle pulse in the first cycle after level falls.

Function
REQ-010 The FSM SHALL have states IDLE, HIGH, GAP; illegal encodings SHALL go to IDLE next cycle.
REQ-011 IDLE: level=0, busy=0; tick=1 SHALL move to HIGH and load cnt = max(hold_len,1)-1.
REQ-012 Latency: tick high before edge n SHALL make level high in the cycle following edge n.
REQ-013 HIGH: level=1; cnt!=0 SHALL decrement; cnt==0 SHALL exit, giving exactly max(hold_len,1) high cycles.
REQ-014 HIGH exit SHALL go to GAP loading gcnt=GAP_LEN-1 when GAP_LEN>0, else to IDLE.
REQ-015 GAP: level=0, busy=1; gcnt SHALL decrement to 0 then go to IDLE; ticks in GAP SHALL be ignored.
REQ-016 With GAP_LEN=0, a tick in the cycle of HIGH exit SHALL be ignored; next pulse needs a tick while in IDLE.
REQ-017 done SHALL assert exactly once per pulse, in the first cycle level is 0 after HIGH, including on retrigger-extended pulses.
REQ-018 hold_len changes while busy SHALL NOT affect the pulse in progress (except a reload per REQ-022).
REQ-019 Counter arithmetic SHALL be unsigned CNT_W bits; hold_len = all-ones SHALL give 2^CNT_W-1 high cycles without wrap.

Reset
REQ-020 reset SHALL force IDLE, cnt=0, gcnt=0, level=0, busy=0, done=0 immediately, including mid-pulse and mid-gap.
REQ-021 First tick after reset deassertion SHALL be handled as from IDLE; no done SHALL be emitted for a pulse cut by reset.

Configuration
REQ-022 With PULSE_STRETCHER_RETRIGGER_EN defined, tick in HIGH SHALL reload cnt = max(hold_len,1)-1, level staying high continuously.
REQ-023 Without PULSE_STRETCHER_RETRIGGER_EN, ticks in HIGH SHALL be ignored and pulse length fixed at acceptance.

Structure
REQ-024 A shared package SHALL hold the state encoding constants (IDLE=2'b00, HIGH=2'b01, GAP=2'b10) and the 2-bit state type.
REQ-025 The down-counter with load/zero-flag SHALL be sub-module stretch_down_counter, instantiated twice (hold, gap).
REQ-026 State register and next-state/output logic SHALL be separate always blocks; outputs SHALL be decoded from state_reg only.

Verification
REQ-027 hold_len=4, GAP_LEN=2, tick 1 cycle at cycle 10 -> level high cycles 11-14, done at 15, busy 11-16, IDLE at 17.
REQ-028 hold_len=0, tick -> level high exactly 1 cycle; hold_len=255, CNT_W=8 -> 255 high cycles, done once.
REQ-029 tick every cycle, hold_len=3, GAP_LEN=2, no retrigger -> pattern 3 high, 3 low (2 gap + 1 idle accept), repeating.
REQ-030 RETRIGGER_EN, hold_len=4, ticks at 10 and 13 -> level high cycles 11-17 continuous, single done at 18.
REQ-031 reset asserted at cycle 13 of REQ-027 stimulus -> level, busy 0 same cycle, no done; tick at 20 -> normal 4-cycle pulse.
REQ-032 hold_len changed 4->9 at cycle 12 mid-pulse (no retrigger) -> pulse remains 4 cycles.
